// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a word-addressed
// instruction memory loaded through a synchronous write port.
module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_BITS  = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_addr,
    input  logic                 imem_we,
    input  logic [ADDR_BITS-1:0] imem_waddr,
    input  logic [31:0]          imem_wdata,
    output logic [31:0]          pc_out,
    output logic [31:0]          if_id_pc,
    output logic [31:0]          if_id_instr,
    output logic                 if_id_valid,
    output logic [31:0]          fetch_count
);

    logic [31:0]          imem [IMEM_DEPTH];
    logic [ADDR_BITS-1:0] fetch_idx;
    logic [31:0]          fetch_instr;
    logic [31:0]          pc_plus4;
    logic [31:0]          branch_target;
    logic [1:0]           unused_branch_lsb;

    // Upper PC bits are ignored so fetch addresses alias modulo IMEM_DEPTH.
    assign fetch_idx         = pc_out[ADDR_BITS+1:2];
    assign fetch_instr       = imem[fetch_idx];
    assign pc_plus4          = pc_out + 32'd4;
    assign branch_target     = {branch_addr[31:2], 2'b00};
    assign unused_branch_lsb = branch_addr[1:0];

    // Memory has no reset; a same-edge write to the fetched word is seen next cycle.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out      <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (branch_taken) begin
            pc_out      <= branch_target;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc_out      <= pc_plus4;
            if_id_pc    <= pc_plus4;
            if_id_instr <= fetch_instr;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan steps followed by a
// randomized phase, all outputs compared against a behavioural model each cycle.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc_out;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural reference state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_valid;

    if_stage #(
        .IMEM_DEPTH(256),
        .ADDR_BITS (8),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc_out      (pc_out),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc_out", pc_out, m_pc);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // One clock edge: the model evaluates the rules on the inputs present at the edge.
    task automatic step();
        logic [31:0] fetched;
        fetched = m_mem[(m_pc / 4) % 256];
        @(posedge clk);
        if (!rst_n) begin
            m_pc = 32'h0; m_ipc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
        end else if (branch_taken) begin
            m_pc = (branch_addr / 4) * 4; m_ipc = 0; m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = fetched; m_ipc = m_pc + 4; m_pc = m_pc + 4;
            m_valid = 1; m_cnt = m_cnt + 1;
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
        #1;
        check_model();
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_addr = 0; imem_we = 0;
    endtask

    initial begin
        rst_n = 0; idle(); imem_waddr = 0; imem_wdata = 0;
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;

        // Load the whole memory under reset
        for (int i = 0; i < 256; i++) begin
            imem_we = 1; imem_waddr = i[7:0];
            case (i)
                0: imem_wdata = 32'h11;
                1: imem_wdata = 32'h22;
                2: imem_wdata = 32'h33;
                3: imem_wdata = 32'h44;
                8: imem_wdata = 32'hAB;
                255: imem_wdata = 32'hCC;
                default: imem_wdata = $urandom;
            endcase
            step();
        end
        imem_we = 0;
        step();
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_valid", {31'b0, if_id_valid}, 32'h0);
        chk("reset_cnt", fetch_count, 32'h0);

        // Sequential fetch
        rst_n = 1;
        step();
        chk("seq1_pc", pc_out, 32'h4);
        chk("seq1_instr", if_id_instr, 32'h11);
        chk("seq1_ipc", if_id_pc, 32'h4);
        step();
        chk("seq2_instr", if_id_instr, 32'h22);
        chk("seq2_cnt", fetch_count, 32'h2);

        // Stall two cycles while 22 is held
        stall = 1;
        step(); step();
        chk("stall_pc", pc_out, 32'h8);
        chk("stall_instr", if_id_instr, 32'h22);
        chk("stall_cnt", fetch_count, 32'h2);
        stall = 0;
        step();
        chk("unstall_instr", if_id_instr, 32'h33);
        chk("unstall_ipc", if_id_pc, 32'hC);
        chk("unstall_cnt", fetch_count, 32'h3);

        // Branch and flush
        branch_taken = 1; branch_addr = 32'h20;
        step();
        chk("br_pc", pc_out, 32'h20);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_instr", if_id_instr, 32'h0);
        idle();
        step();
        chk("br_target_instr", if_id_instr, 32'hAB);
        chk("br_target_ipc", if_id_pc, 32'h24);
        branch_taken = 1; branch_addr = 32'h23;
        step();
        chk("br_misalign_pc", pc_out, 32'h20);
        idle();
        step();

        // Branch beats stall
        stall = 1; branch_taken = 1; branch_addr = 32'h40;
        step();
        chk("brstall_pc", pc_out, 32'h40);
        chk("brstall_valid", {31'b0, if_id_valid}, 32'h0);
        chk("brstall_cnt", fetch_count, 32'h5);

        // Wrap and alias: fetch at FFFF_FFFC reads word 255, then PC wraps
        stall = 0; branch_addr = 32'hFFFF_FFFC;
        imem_we = 1; imem_waddr = 8'd0; imem_wdata = 32'hDD;
        step();
        idle();
        step();
        chk("wrap_instr", if_id_instr, 32'hCC);
        chk("wrap_ipc", if_id_pc, 32'h0);
        chk("wrap_pc", pc_out, 32'h0);
        step();
        chk("alias_instr", if_id_instr, 32'hDD);
        chk("alias_pc", pc_out, 32'h4);

        // Write during fetch returns old data; refetch sees the new word
        branch_taken = 1; branch_addr = 32'h8;
        step();
        idle();
        imem_we = 1; imem_waddr = 8'd2; imem_wdata = 32'h99;
        step();
        chk("wdf_old", if_id_instr, 32'h33);
        imem_we = 0; branch_taken = 1; branch_addr = 32'h8;
        step();
        idle();
        step();
        chk("wdf_new", if_id_instr, 32'h99);

        // Mid-run reset keeps memory contents
        rst_n = 0;
        step();
        chk("midrst_pc", pc_out, 32'h0);
        chk("midrst_cnt", fetch_count, 32'h0);
        chk("midrst_instr", if_id_instr, 32'h0);
        rst_n = 1;
        step(); step(); step();
        chk("retain_instr", if_id_instr, 32'h99);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 99) >= 2);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            branch_addr  = ($urandom_range(0, 3) == 0) ? $urandom : {22'b0, $urandom_range(0, 1023)};
            imem_we      = ($urandom_range(0, 4) == 0);
            imem_waddr   = ($urandom_range(0, 1) == 0) ? 8'((m_pc / 4) % 256) : 8'($urandom);
            imem_wdata   = $urandom;
            step();
        end
        idle();
        rst_n = 1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, together with the IF/ID pipeline register.
- Holds the PC and an internal word-addressed instruction memory; the bench loads the memory through a write port.
- Presents the fetched instruction and PC+4 to decode.
- Redirects to the branch target computed in the execute stage. A redirect squashes the instruction currently being fetched.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words; must be a power of two.
- ADDR_BITS, 8, log2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000, PC value after reset; word-aligned.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hazard-unit freeze; holds the PC and the IF/ID register.
- branch_taken  input  1  redirect request from execute stage.
- branch_addr  input  32  redirect target from execute stage.
- imem_we  input  1  instruction-memory write enable.
- imem_waddr  input  ADDR_BITS  word index to write.
- imem_wdata  input  32  word to write.
- pc_out  output  32  current fetch PC (registered).
- if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (rst_n=0 at a rising edge) overrides every other input and applies mid-operation too. Resulting values:
  - pc_out = RESET_PC.
  - if_id_pc, if_id_instr, fetch_count = 0.
  - if_id_valid = 0.
  - Instruction-memory contents are NOT cleared.
- Fetch index = pc_out[ADDR_BITS+1:2]. Upper PC bits are ignored, so addresses alias modulo IMEM_DEPTH words. The instruction read is combinational from the array.
- PC update, by priority:
  - branch_taken=1: pc_out <= {branch_addr[31:2],2'b00}. Misaligned low bits are dropped. Branch wins over stall.
  - else stall=1: pc_out holds.
  - else: pc_out <= pc_out + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID update, by the same priority:
  - branch_taken=1: flush. if_id_valid <= 0, if_id_instr <= 0 (NOP), if_id_pc <= 0, fetch_count unchanged.
  - else stall=1: all IF/ID outputs and fetch_count hold.
  - else: if_id_instr <= imem[index], if_id_pc <= pc_out + 4, if_id_valid <= 1, fetch_count <= fetch_count + 1 (wraps at 2^32).
- Latency: an instruction at PC p appears on if_id_instr one cycle after pc_out = p, provided no stall or branch in that cycle.
- Branch penalty: exactly one bubble. The target instruction appears two edges after branch_taken is sampled.
- Instruction-memory write:
  - Synchronous; the new word is visible from the next cycle.
  - A write to the word being fetched in the same cycle returns the old data.
  - Writes are independent of stall, branch_taken and rst_n.
- stall and branch_taken held for multiple cycles: each cycle is evaluated independently with the priority above.
- Sequential state: PC register, IF/ID register, fetch counter. Nothing else is sequential apart from the memory array.

Test Plan:
- Reset and sequential fetch. Load words 0..3 = 32'h11,22,33,44; release reset with RESET_PC=0; no stall or branch.
  - pc_out steps 0,4,8,C.
  - if_id_instr = 11,22,33 with if_id_pc = 4,8,C on successive cycles.
  - fetch_count increments 1,2,3.
- Stall. Assert stall for 2 cycles while if_id_instr=22.
  - pc_out and all IF/ID outputs hold for 2 cycles; fetch_count unchanged.
  - After stall drops: if_id_instr=33 on the next edge.
- Branch and flush. Pulse branch_taken with branch_addr=32'h20 (word 8 = 32'hAB) while pc_out=8.
  - Next edge: pc_out=20, if_id_valid=0, if_id_instr=0.
  - Following edge: if_id_instr=AB, if_id_pc=24.
  - Repeat with branch_addr=32'h23: pc_out=32'h20.
- Branch beats stall. Assert stall and branch_taken together with branch_addr=32'h40.
  - pc_out=32'h40, if_id_valid=0, fetch_count unchanged.
- Wrap and alias. IMEM_DEPTH=256, RESET_PC=32'hFFFF_FFFC, word 255=32'hCC, word 0=32'hDD.
  - if_id_instr=CC with if_id_pc=0, then DD.
  - pc_out wraps to 0 then 4.
- Write-during-fetch and mid-run reset.
  - Write word 2=32'h99 in the cycle pc_out=8: if_id_instr shows the old word.
  - Refetch of PC 8 after a branch shows 99.
  - Assert rst_n=0 for one cycle mid-run: all outputs return to reset values; memory retains 99.
